mips_cpu: RTL and testbench
===========================

MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 Port: rst  input  1  reset, synchronous, active-low (rst==0 sampled at rising clk edge resets).
REQ-003 No other ports; program/data loading via hierarchical access only.
REQ-004 Parameter: PC_RESET, 32'h0000_3000, PC value after reset.
REQ-005 Parameter: IM_WORDS, 1024, instruction memory depth (32-bit words).
REQ-006 Parameter: DM_WORDS, 1024, data memory depth (32-bit words).
REQ-007 Instruction memory SHALL be a submodule instance named IM containing reg [31:0] array im[0:IM_WORDS-1]; data memory SHALL be instance DM containing reg [31:0] array mem[0:DM_WORDS-1] (bench loads both with $readmemh).

Function
REQ-008 Single-cycle datapath: one instruction fetched, executed and retired per rising clk edge.
REQ-009 Fetch: instruction = IM.im[(PC - PC_RESET) >> 2], index wraps modulo IM_WORDS; IM read is combinational.
REQ-010 Supported: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, sll 0 (nop); any other encoding SHALL execute as nop (PC+4, no state change).
REQ-011 Register file: 32x32, two combinational read ports, one write port written on rising edge; $0 reads 0 always, writes to $0 ignored.
REQ-012 addu/subu: rd <= rs +/- rt modulo 2^32, no overflow exception.
REQ-013 ori: rt <= rs | zero_ext(imm16); lui: rt <= {imm16, 16'h0}.
REQ-014 lw: rt <= DM.mem[addr[11:2]], addr = rs + sign_ext(imm16); sw: DM.mem[addr[11:2]] <= rt on rising edge; addr[1:0] ignored; index wraps modulo DM_WORDS.
REQ-015 DM read combinational, write synchronous; lw of a word stored by the preceding sw returns the new value.
REQ-016 Next PC: default PC+4; beq taken when rs==rt -> PC+4+(sign_ext(imm16)<<2); j/jal -> {PC+4[31:28], instr_index, 2'b00}; jr -> rs.
REQ-017 jal writes PC+4 into $31 in the same cycle as the jump.
REQ-018 jr reading $31 written by the immediately preceding jal SHALL see the new value (register write precedes next read).
REQ-019 No delay slots; no exceptions, interrupts or stalls.

Reset
REQ-020 While rst==0 at a rising edge: PC <= PC_RESET, all 32 GPRs <= 0, no memory write occurs.
REQ-021 IM and DM contents SHALL NOT be cleared by reset; memories loaded before or after reset are retained.
REQ-022 Reset asserted mid-program SHALL abort in-flight instruction effects (no register or DM write in that cycle) and restart from PC_RESET.

Configuration
REQ-023 Macro MIPS_TRACE_EN: when defined, on every retired GPR write the design SHALL $display "@<PC hex>: $<reg dec> <= <data hex>" and on every DM write "@<PC hex>: *<addr hex> <= <data hex>"; writes to $0 not printed.
REQ-024 Without MIPS_TRACE_EN: no simulation output; functional behaviour identical.

Verification
REQ-025 Reset: hold rst=0 two edges, release -> PC==32'h3000, $1..$31 ==0, first fetch from IM.im[0].
REQ-026 ALU: ori $1,$0,0x1234; lui $2,0xFFFF; addu $3,$1,$2; subu $4,$0,$1 -> $3==32'hFFFF1234, $4==32'hFFFFEDCC.
REQ-027 Memory: ori $1,$0,8; sw $1,4($1); lw $5,4($1) -> DM.mem[3]==8, $5==8; write to $0 via ori $0,$0,5 leaves $0==0.
REQ-028 Branch: beq $0,$0,+1 at 0x3000 -> next PC 0x3008; beq with unequal regs -> 0x3004.
REQ-029 Calls: jal to 0x3020 at PC 0x3010 -> $31==0x3014, PC 0x3020; jr $31 next -> PC 0x3014.
REQ-030 Mid-run reset: assert rst=0 during a sw -> DM unchanged, PC==0x3000 next cycle; with MIPS_TRACE_EN defined, trace line count equals non-$0 writes.

Source files
------------

// File: rtl/mips_cpu.sv
// rtl/mips_cpu.sv - single-cycle MIPS subset core with internal instruction and data memories.
// Optional trace output is enabled by defining MIPS_TRACE_EN.

module mips_im #(
   parameter int IM_WORDS = 1024,
   parameter int AW       = 10
) (
   input  logic [AW-1:0] idx_i,
   output logic [31:0]   instr_o
);
   reg [31:0] im [0:IM_WORDS-1];

   assign instr_o = im[idx_i];
endmodule

module mips_dm #(
   parameter int DM_WORDS = 1024,
   parameter int AW       = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] idx_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);
   reg [31:0] mem [0:DM_WORDS-1];

   always @(posedge clk_i) begin
      if (we_i) mem[idx_i] <= wdata_i;
   end

   assign rdata_o = mem[idx_i];
endmodule

module mips_cpu #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          IM_WORDS = 1024,
   parameter int          DM_WORDS = 1024
) (
   input logic clk,
   input logic rst
);
   localparam int IAW = $clog2(IM_WORDS);
   localparam int DAW = $clog2(DM_WORDS);

   typedef enum logic [3:0] {
      OP_NOP, OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_JR
   } op_e;

   logic [31:0] pc_q, pc_d;
   logic [31:0] gpr_q [0:31];
   logic [31:0] instr, im_word, dm_word, dm_addr, dm_rdata;
   logic [31:0] rs_val, rt_val, pc_plus4, imm_sext, imm_zext;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  opcode, funct;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   op_e         op;
   logic        wr_en, dm_we;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic        unused_bits;

   // Both memories are word-indexed and wrap at their depth.
   assign im_word = ((pc_q - PC_RESET) >> 2) % IM_WORDS;
   assign dm_word = (dm_addr >> 2) % DM_WORDS;
   assign unused_bits = ^{im_word[31:IAW], dm_word[31:DAW], dm_addr[1:0]};

   mips_im #(.IM_WORDS(IM_WORDS), .AW(IAW)) IM (
      .idx_i   (im_word[IAW-1:0]),
      .instr_o (instr)
   );

   mips_dm #(.DM_WORDS(DM_WORDS), .AW(DAW)) DM (
      .clk_i   (clk),
      .we_i    (dm_we),
      .idx_i   (dm_word[DAW-1:0]),
      .wdata_i (rt_val),
      .rdata_o (dm_rdata)
   );

   assign opcode      = instr[31:26];
   assign rs          = instr[25:21];
   assign rt          = instr[20:16];
   assign rd          = instr[15:11];
   assign shamt       = instr[10:6];
   assign funct       = instr[5:0];
   assign imm16       = instr[15:0];
   assign instr_index = instr[25:0];
   assign imm_sext    = {{16{imm16[15]}}, imm16};
   assign imm_zext    = {16'h0000, imm16};
   assign pc_plus4    = pc_q + 32'd4;
   assign rs_val      = (rs == 5'd0) ? 32'h0 : gpr_q[rs];
   assign rt_val      = (rt == 5'd0) ? 32'h0 : gpr_q[rt];
   assign dm_addr     = rs_val + imm_sext;

   // R-type encodings with a non-zero shamt are not part of the subset and fall to nop.
   always_comb begin
      op = OP_NOP;
      case (opcode)
         6'h00: begin
            if (shamt == 5'd0) begin
               case (funct)
                  6'h21:   op = OP_ADDU;
                  6'h23:   op = OP_SUBU;
                  6'h08:   op = OP_JR;
                  default: op = OP_NOP;
               endcase
            end
         end
         6'h0d:   op = OP_ORI;
         6'h0f:   op = OP_LUI;
         6'h23:   op = OP_LW;
         6'h2b:   op = OP_SW;
         6'h04:   op = OP_BEQ;
         6'h02:   op = OP_J;
         6'h03:   op = OP_JAL;
         default: op = OP_NOP;
      endcase
   end

   always_comb begin
      pc_d    = pc_plus4;
      wr_en   = 1'b0;
      wr_idx  = 5'd0;
      wr_data = 32'h0;
      dm_we   = 1'b0;
      case (op)
         OP_ADDU: begin wr_en = 1'b1; wr_idx = rd; wr_data = rs_val + rt_val; end
         OP_SUBU: begin wr_en = 1'b1; wr_idx = rd; wr_data = rs_val - rt_val; end
         OP_ORI:  begin wr_en = 1'b1; wr_idx = rt; wr_data = rs_val | imm_zext; end
         OP_LUI:  begin wr_en = 1'b1; wr_idx = rt; wr_data = {imm16, 16'h0000}; end
         OP_LW:   begin wr_en = 1'b1; wr_idx = rt; wr_data = dm_rdata; end
         OP_SW:   dm_we = rst;
         OP_BEQ:  if (rs_val == rt_val) pc_d = pc_plus4 + (imm_sext << 2);
         OP_J:    pc_d = {pc_plus4[31:28], instr_index, 2'b00};
         OP_JAL: begin
            pc_d    = {pc_plus4[31:28], instr_index, 2'b00};
            wr_en   = 1'b1;
            wr_idx  = 5'd31;
            wr_data = pc_plus4;
         end
         OP_JR:   pc_d = rs_val;
         default: pc_d = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= PC_RESET;
         for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
      end else begin
         pc_q <= pc_d;
         if (wr_en && wr_idx != 5'd0) gpr_q[wr_idx] <= wr_data;
      end
   end

`ifdef MIPS_TRACE_EN
   always @(posedge clk) begin
      if (rst && wr_en && wr_idx != 5'd0) $display("@%h: $%0d <= %h", pc_q, wr_idx, wr_data);
      if (dm_we) $display("@%h: *%h <= %h", pc_q, dm_addr, rt_val);
   end
`else
   // Trace disabled: the core produces no simulation output.
`endif
endmodule

// File: tb/tb_mips_cpu.sv
// tb/tb_mips_cpu.sv - scoreboard bench for mips_cpu against an instruction-level reference model.

module tb_mips_cpu;
   logic clk;
   logic rst;

   mips_cpu dut (.clk(clk), .rst(rst));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          widx;
      logic [31:0] wval;
      int          midx;
      logic [31:0] mval;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pc_hist[$];
   logic [31:0] m_pc;
   logic [31:0] m_gpr [32];
   logic [31:0] m_im  [1024];
   logic [31:0] m_dm  [1024];
   int          n_chk = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(int op, logic [31:0] target);
      return {6'(op), target[27:2]};
   endfunction

   task automatic load_im(input int i, input logic [31:0] w);
      m_im[i] = w;
      dut.IM.im[i] = w;
   endtask

   task automatic load_dm(input int i, input logic [31:0] w);
      m_dm[i] = w;
      dut.DM.mem[i] = w;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) begin
         load_im(i, 32'h0);
         load_dm(i, 32'h0);
      end
   endtask

   // Architectural interpreter: one call executes one instruction and reports its visible effects.
   function automatic exp_t model_step();
      exp_t        e;
      logic [31:0] w, a, b, addr, sext, pc4, val;
      int          dst, op, fn, sh;
      w    = m_im[((m_pc - 32'h3000) >> 2) % 1024];
      op   = int'(w[31:26]);
      fn   = int'(w[5:0]);
      sh   = int'(w[10:6]);
      a    = m_gpr[w[25:21]];
      b    = m_gpr[w[20:16]];
      sext = {{16{w[15]}}, w[15:0]};
      addr = a + sext;
      pc4  = m_pc + 4;
      e.pc = pc4; e.widx = 0; e.wval = 0; e.midx = -1; e.mval = 0;
      dst  = 0; val = 0;
      case (op)
         0: if (sh == 0) begin
            if (fn == 'h21) begin dst = int'(w[15:11]); val = a + b; end
            else if (fn == 'h23) begin dst = int'(w[15:11]); val = a - b; end
            else if (fn == 'h08) e.pc = a;
         end
         'h0d: begin dst = int'(w[20:16]); val = a | {16'h0, w[15:0]}; end
         'h0f: begin dst = int'(w[20:16]); val = {w[15:0], 16'h0}; end
         'h23: begin dst = int'(w[20:16]); val = m_dm[addr[11:2]]; end
         'h2b: begin m_dm[addr[11:2]] = b; e.midx = int'(addr[11:2]); e.mval = b; end
         'h04: if (a == b) e.pc = pc4 + (sext << 2);
         'h02: e.pc = {pc4[31:28], w[25:0], 2'b00};
         'h03: begin e.pc = {pc4[31:28], w[25:0], 2'b00}; dst = 31; val = pc4; end
         default: ;
      endcase
      if (dst != 0) begin
         m_gpr[dst] = val;
         e.widx = dst;
         e.wval = val;
      end
      m_pc = e.pc;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         pc_hist.push_back(dut.pc_q);
         chk("pc", dut.pc_q, e.pc);
         if (e.widx != 0) chk($sformatf("gpr%0d", e.widx), dut.gpr_q[e.widx], e.wval);
         if (e.midx >= 0) chk($sformatf("dm[%0d]", e.midx), dut.DM.mem[e.midx], e.mval);
      end
   end

   task automatic run(input int n);
      mon_en = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_pc", dut.pc_q, 32'h3000);
      for (int i = 1; i < 32; i++) chk($sformatf("reset_gpr%0d", i), dut.gpr_q[i], 32'h0);
      chk("first_fetch", dut.instr, m_im[0]);
      m_pc = 32'h3000;
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      pc_hist.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(model_step());
      rst = 1'b1;
      @(posedge clk);
      #1 mon_en = 1'b1;
      for (int c = 0; c < n + 20; c++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL run_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      mon_en = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      int r, off;
      r = $urandom_range(0, 99);
      if (r < 15)      return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 'h21);
      else if (r < 25) return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 'h23);
      else if (r < 40) return enc_i('h0d, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      else if (r < 48) return enc_i('h0f, 0, $urandom_range(0, 7), $urandom_range(0, 65535));
      else if (r < 60) return enc_i('h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      else if (r < 72) return enc_i('h2b, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
      else if (r < 82) begin
         off = int'($urandom_range(0, 12)) - 6;
         return enc_i('h04, $urandom_range(0, 3), $urandom_range(0, 3), off);
      end
      else if (r < 87) return enc_j('h02, 32'h3000 + 4 * $urandom_range(0, 1023));
      else if (r < 91) return enc_j('h03, 32'h3000 + 4 * $urandom_range(0, 1023));
      else if (r < 94) return enc_r(31, 0, 0, 'h08);
      else if (r < 96) return enc_r($urandom_range(0, 7), 0, 0, 'h08);
      else             return $urandom;
   endfunction

   initial begin
      rst = 1'b0;

      clear_mem();
      load_im(0, enc_i('h0d, 0, 1, 'h1234));
      load_im(1, enc_i('h0f, 0, 2, 'hFFFF));
      load_im(2, enc_r(1, 2, 3, 'h21));
      load_im(3, enc_r(0, 1, 4, 'h23));
      run(4);
      chk("alu_ori", dut.gpr_q[1], 32'h0000_1234);
      chk("alu_addu", dut.gpr_q[3], 32'hFFFF_1234);
      chk("alu_subu", dut.gpr_q[4], 32'hFFFF_EDCC);

      clear_mem();
      load_im(0, enc_i('h0d, 0, 1, 8));
      load_im(1, enc_i('h2b, 1, 1, 4));
      load_im(2, enc_i('h23, 1, 5, 4));
      load_im(3, enc_i('h0d, 0, 0, 5));
      run(4);
      chk("mem_sw", dut.DM.mem[3], 32'h8);
      chk("mem_lw", dut.gpr_q[5], 32'h8);
      chk("zero_reg", dut.gpr_q[0], 32'h0);

      clear_mem();
      load_im(0, enc_i('h04, 0, 0, 1));
      load_im(1, enc_i('h0d, 0, 1, 1));
      load_im(2, enc_i('h0d, 0, 2, 7));
      load_im(3, enc_i('h04, 2, 0, 5));
      run(3);
      chk("beq_taken", pc_hist[0], 32'h3008);
      chk("beq_not_taken", pc_hist[2], 32'h3010);
      chk("beq_skip", dut.gpr_q[1], 32'h0);

      clear_mem();
      load_im(4, enc_j('h03, 32'h3020));
      load_im(8, enc_r(31, 0, 0, 'h08));
      run(7);
      chk("jal_pc", pc_hist[4], 32'h3020);
      chk("jal_link", dut.gpr_q[31], 32'h3014);
      chk("jr_pc", pc_hist[5], 32'h3014);

      clear_mem();
      load_im(0, enc_i('h0d, 0, 1, 'h55));
      load_im(1, enc_i('h2b, 0, 1, 0));
      load_dm(0, 32'hDEAD_BEEF);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_at_sw", dut.pc_q, 32'h3004);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_dm", dut.DM.mem[0], 32'hDEAD_BEEF);
      chk("midrst_pc", dut.pc_q, 32'h3000);
      chk("midrst_gpr", dut.gpr_q[1], 32'h0);

      for (int i = 0; i < 1024; i++) begin
         load_im(i, rand_instr());
         load_dm(i, $urandom);
      end
      run(3000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
